// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 sensor-side emulator: validates a trigger pulse, waits the burst delay,
// then drives an echo pulse encoding dist_cm. Define EMU_JITTER_EN to add 0..15 cycles of LFSR jitter.
module hcsr04_echo_emulator #(
  parameter int unsigned TRIG_MIN_CYC    = 500,
  parameter int unsigned BURST_DELAY_CYC = 10000,
  parameter int unsigned CYC_PER_CM      = 2900,
  parameter int unsigned MAX_CM          = 400,
  parameter int unsigned TIMEOUT_CYC     = 1900000,
  parameter int unsigned HOLDOFF_CYC     = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigg,
  input  logic [9:0] dist_cm,
  input  logic       target_present,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic       done
);

  localparam int unsigned PROD_MAX = MAX_CM * CYC_PER_CM;
  localparam int unsigned W_MAX    = (PROD_MAX > TIMEOUT_CYC) ? PROD_MAX : TIMEOUT_CYC;
  localparam int unsigned WW       = $clog2(W_MAX + 1);
  localparam int unsigned C_MAX0   = W_MAX + 16;
  localparam int unsigned C_MAX1   = (C_MAX0 > BURST_DELAY_CYC) ? C_MAX0 : BURST_DELAY_CYC;
  localparam int unsigned C_MAX2   = (C_MAX1 > HOLDOFF_CYC) ? C_MAX1 : HOLDOFF_CYC;
  localparam int unsigned C_MAX    = (C_MAX2 > TRIG_MIN_CYC) ? C_MAX2 : TRIG_MIN_CYC;
  localparam int unsigned CW       = $clog2(C_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t          state_q, state_d;
  logic            trig_m, trig_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   width_q, width_d, width_cap;
  logic [CW-1:0]   echo_len;
  logic            echo_d, busy_d, trig_err_d, done_d;

`ifdef EMU_JITTER_EN
  logic [15:0] lfsr_q;
  logic [3:0]  jit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
      jit_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (state_q == S_BURST && state_d == S_ECHO)
        jit_q <= lfsr_q[3:0];
    end
  end

  always_comb echo_len = CW'(width_q) + CW'(jit_q);
`else
  always_comb echo_len = CW'(width_q);
`endif

  // dist_cm <= MAX_CM in the multiply branch, so the WW-bit product cannot overflow
  always_comb begin
    if (!target_present || 32'(dist_cm) > MAX_CM)
      width_cap = WW'(TIMEOUT_CYC);
    else if (dist_cm == 10'd0)
      width_cap = WW'(CYC_PER_CM);
    else
      width_cap = WW'(dist_cm) * WW'(CYC_PER_CM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_m   <= 1'b0;
      trig_s   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      width_q  <= '0;
      echo     <= 1'b0;
      busy     <= 1'b0;
      trig_err <= 1'b0;
      done     <= 1'b0;
    end else begin
      trig_m   <= trigg;
      trig_s   <= trig_m;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      echo     <= echo_d;
      busy     <= busy_d;
      trig_err <= trig_err_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_d    = width_q;
    trig_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_s) begin
          state_d = S_TRIG_HI;
          cnt_d   = CW'(1);
        end
      end
      S_TRIG_HI: begin
        if (trig_s) begin
          if (cnt_q < CW'(TRIG_MIN_CYC))
            cnt_d = cnt_q + CW'(1);
        end else if (cnt_q >= CW'(TRIG_MIN_CYC)) begin
          state_d = S_BURST;
          cnt_d   = '0;
          width_d = width_cap;
        end else begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          trig_err_d = 1'b1;
        end
      end
      S_BURST: begin
        if (cnt_q == CW'(BURST_DELAY_CYC - 1)) begin
          state_d = S_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ECHO: begin
        if (cnt_q == echo_len - CW'(1)) begin
          state_d = S_HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == CW'(HOLDOFF_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of the next-state decode
    echo_d = (state_d == S_ECHO);
    busy_d = (state_d inside {S_BURST, S_ECHO, S_HOLDOFF});
    done_d = (state_q == S_ECHO) && (state_d == S_HOLDOFF);
  end

endmodule
